// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Used by the fetch unit top and its fetch queue.
package instruction_fetch_unit_pkg;

  localparam logic [5:0]  OP_J             = 6'h02;
  localparam logic [31:0] INSTR_NOP        = 32'h00000000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00000000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // A j whose region-relative target lands back on its own address spins forever.
  function automatic logic is_self_jump(input logic [31:0] instr, input logic [31:0] pc);
    logic [31:0] pc_plus4;
    logic [31:0] target;
    pc_plus4 = pc + 32'd4;
    target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    return (instr[5+26:26] == OP_J) && (target == pc);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of instruction-memory, redirect and decode-handshake signals.
// master = fetch unit side, slave = memory/pipeline side.
interface instruction_fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        halted;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect,
    input  redirect_target,
    input  id_ready,
    output id_valid,
    output id_instruction,
    output id_pc,
    output id_pc_plus4,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect,
    output redirect_target,
    output id_ready,
    input  id_valid,
    input  id_instruction,
    input  id_pc,
    input  id_pc_plus4,
    input  halted
  );

endinterface

// File: rtl/instruction_fetch_unit_queue.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs.
// Flush wins over push/pop; a push into a full queue is accepted only alongside a pop.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           data_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;

  fetch_entry_t      mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [CNTW-1:0]   count_q;
  logic              do_push;
  logic              do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNTW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNTW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNTW'(1);
      end
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, enqueues memory words with their PC and feeds decode.
// Redirects flush and reload the PC; a self-jump can park fetching until the next redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC          = DEFAULT_RESET_PC,
  parameter int unsigned QUEUE_DEPTH       = 2,
  parameter bit          HALT_ON_SELF_JUMP = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          halted_q, halted_d;
  logic [31:0]   pc_plus4;

  fetch_entry_t  head;
  fetch_entry_t  new_entry;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          head_valid;
  logic          pop;
  logic          push;
  logic          halt_push;

  assign pc_plus4   = pc_q + 32'd4;
  assign head_valid = (count != '0);
  assign new_entry  = '{instr: bus.imem_data, pc: pc_q};

  // Redirect overrides both sides of the queue for the cycle it is asserted.
  assign pop       = !empty && bus.id_ready && !bus.redirect;
  assign push      = (state_q == S_RUN) && !bus.redirect && (!full || pop);
  assign halt_push = push && HALT_ON_SELF_JUMP && is_self_jump(bus.imem_data, pc_q);

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect),
    .data_i  (new_entry),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    if (bus.redirect) begin
      state_d  = S_RUN;
      pc_d     = bus.redirect_target & ~32'h3;
      halted_d = 1'b0;
    end else begin
      unique case (state_q)
        S_BOOT: state_d = S_RUN;
        S_RUN: begin
          if (halt_push) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else if (push) begin
            pc_d = pc_plus4;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Decode sees zeros rather than stale queue contents whenever nothing is valid.
  assign bus.imem_addr      = pc_q;
  assign bus.id_valid       = head_valid;
  assign bus.id_instruction = head_valid ? head.instr : INSTR_NOP;
  assign bus.id_pc          = head_valid ? head.pc : 32'd0;
  assign bus.id_pc_plus4    = head_valid ? (head.pc + 32'd4) : 32'd0;
  assign bus.halted         = halted_q;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of the instruction memory and downstream-feeding the decoder. Owns the PC register, drives the memory address combinationally from it, and captures the returned word with its PC into a small fetch queue. Presents instructions to decode over a valid/ready handshake. Applies redirects (branch/jump resolved later in the pipeline) and detects the self-loop "j to own address" idiom to halt fetching.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
QUEUE_DEPTH, 2, fetch queue entries (power of two, >=2).
HALT_ON_SELF_JUMP, 1, 1 = stop fetching after enqueuing a j whose target equals its own PC.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (reset=0 asserts)
imem_addr  output  32  instruction memory address, always equal to pc register
imem_data  input  32  instruction word returned combinationally for imem_addr
redirect  input  1  flush queue and load new PC this cycle
redirect_target  input  32  new PC; bits [1:0] forced to 00 on load
id_ready  input  1  decode accepts head entry this cycle
id_valid  output  1  head entry valid
id_instruction  output  32  head instruction word
id_pc  output  32  head instruction PC
id_pc_plus4  output  32  id_pc + 4 (mod 2^32)
halted  output  1  fetch stopped on self-jump

Behaviour:
- Reset (async, reset=0): pc=RESET_PC, queue count=0, state=S_BOOT, id_valid=0, halted=0; id_instruction/id_pc/id_pc_plus4 read 0.
- Whenever id_valid=0, id_instruction, id_pc and id_pc_plus4 are driven to 0.
- States: S_BOOT -> S_RUN unconditionally after one cycle (no enqueue in S_BOOT). S_RUN -> S_HALT on halting enqueue. S_HALT -> S_RUN only on redirect. S_RUN/S_BOOT + redirect -> S_RUN.
- Pop: id_valid && id_ready at a clock edge removes head. id_valid = (count != 0).
- Enqueue (S_RUN, no redirect): allowed when count<QUEUE_DEPTH, or count==QUEUE_DEPTH and a pop occurs the same cycle. Entry {imem_data, pc}; pc <= pc+4, wrapping 0xFFFFFFFC -> 0x00000000. If blocked, pc holds and imem_addr is stable.
- Latency: word at pc fetched in cycle N appears at head (id_valid=1) in cycle N+1 if the queue was empty.
- Self-jump: imem_data[31:26]==6'h02 and {pc_plus4[31:28], imem_data[25:0], 2'b00}==pc. When HALT_ON_SELF_JUMP=1 and this word is enqueued: state->S_HALT, halted=1 next cycle, pc holds. Queue still drains normally in S_HALT; no further enqueues.
- Redirect has top priority: that edge sets count=0 (pop ignored), pc=redirect_target&~3, halted=0, state=S_RUN; no enqueue that cycle. Target fetched in cycle N+1, valid at head in N+2.
- Redirect during S_BOOT: applies as above, boot cycle is consumed.
- Reset asserted mid-operation: immediately returns to reset values; queue contents discarded.
- Simultaneous push and pop at full: count unchanged, both occur.

Decomposition:
- Shared package: OP_J = 6'h02, state encoding (S_BOOT, S_RUN, S_HALT), INSTR_NOP = 32'h00000000, default RESET_PC.
- One sub-module: fetch_queue, synchronous FIFO of {instruction, pc} with push/pop/flush, count, full/empty flags, same clk/reset.

Test Plan:
- Reset release, id_ready=1, memory at 0x0: 0x20042f5b, 0x2405cfc7 -> S_BOOT cycle, imem_addr=0x0 then 0x4; id_valid rises with id_instruction=0x20042f5b, id_pc=0x0, id_pc_plus4=0x4.
- id_ready=0 for 5 cycles from reset -> exactly 2 entries (pc 0x0, 0x4) enqueued, pc holds at 0x8; id_ready=1 -> entries drain in order, fetch resumes at 0x8 without gaps.
- Word 0x0800000b at 0x2C -> enqueued, halted=1 next cycle, imem_addr stays 0x2C, queue drains, id_valid falls.
- While halted, redirect=1, redirect_target=0x00000019 -> pc=0x18, halted=0, id_valid=0 next cycle, head id_pc=0x18 two cycles after redirect.
- Queue full and redirect with id_ready=1 same cycle -> no pop counted, count=0, no stale entry ever presented.
- pc=0xFFFFFFFC, no halt -> next imem_addr=0x00000000; id_pc_plus4 of that head=0x00000000; assert reset=0 mid-stream -> all outputs zero asynchronously.
